z80_bus_sequencer: RTL and testbench
====================================

# z80_bus_sequencer

Z80 bus-cycle sequencer sitting directly upstream of the memory chip-select decoder: it turns single-cycle transfer requests from the CPU core into T-state-accurate, active-low `m1`/`mreq`/`rd`/`wr` strobes plus address and write data. It implements opcode fetch (M1), memory read and memory write cycles, inserts wait states from `wait_n`, and returns captured read data to the core with a one-cycle `done` pulse. No refresh cycle is generated, so `mreq` never goes low with `m1` high outside a real data access, and the downstream data-RAM select stays clean.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width

- `clk`  in  1  system clock, all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  1  transfer request from core, sampled when `ready`=1
- `req_type`  in  2  00 fetch, 01 read, 10 write, 11 reserved
- `req_addr`  in  ADDR_W  transfer address
- `req_wdata`  in  DATA_W  write data
- `ready`  out  1  sequencer can accept `req` this cycle
- `done`  out  1  one-cycle pulse in the final T-state of a cycle
- `rdata`  out  DATA_W  captured data for fetch/read, held until next capture
- `m1`  out  1  active-low opcode-fetch strobe
- `mreq`  out  1  active-low memory request
- `rd`  out  1  active-low read strobe
- `wr`  out  1  active-low write strobe
- `address`  out  ADDR_W  bus address
- `dout`  out  DATA_W  bus write data
- `din`  in  DATA_W  bus read data
- `wait_n`  in  1  active-low wait, synchronous to `clk`

## Operation
- States: IDLE, T1, T2, TW, T3, T4. All bus outputs are registered and decoded from the next state, so the outputs are valid in the same cycle as the state.
- Acceptance happens when `ready`=1 and `req`=1 and `req_type`!=11. The request fields are latched into internal registers, and later changes on `req_*` are ignored. `req_type`=11 is silently dropped: no cycle is started and no `done` is issued.
- `ready`=1 in IDLE and in the final T-state (where `done`=1). This allows back-to-back cycles with no idle gap.
- Fetch: T1 -> T2 -> TW* -> T3 -> T4 -> IDLE, or directly to T1 if a new request is accepted.
  - `m1`, `mreq` and `rd` are low in T1, T2 and TW, and high in T3 and T4.
  - `din` is captured into `rdata` on the edge leaving T2/TW.
  - `done` is asserted in T4.
- Read: T1 -> T2 -> TW* -> T3.
  - `mreq` and `rd` are low in T1 through T3. `m1` stays high.
  - `din` is captured on the edge leaving T3.
  - `done` is asserted in T3, and the capture lands one edge later, together with the return to IDLE or T1.
- Write: T1 -> T2 -> TW* -> T3.
  - `mreq` is low in T1 through T3. `wr` is low in T2, TW and T3.
  - `dout` = latched data from T1 until the next write.
  - `done` is asserted in T3.
- Wait: `wait_n` is sampled at the end of T2 and of each TW. A low sample means enter or stay in TW; a high sample means proceed to T3. The number of wait states is unbounded.
- `address` holds the latched address from T1 through the last T-state. It keeps its last value in IDLE.

## Timing
- Reset values:
  - state IDLE, `ready`=1, `done`=0
  - `m1`=`mreq`=`rd`=`wr`=1
  - `address`=0, `dout`=0, `rdata`=0
- Reset asserted mid-cycle forces these values immediately, whatever the state (asynchronous). Any in-flight transfer is abandoned with no `done`.
- Cycle lengths with zero wait states, counted from the acceptance edge to the `done` cycle inclusive:
  - fetch: 4 cycles
  - read and write: 3 cycles
  - each wait state adds exactly 1 cycle
- `rdata` is valid from the cycle after the capture edge:
  - fetch: in T3, before `done`
  - read: the cycle after `done`
- The core must use `rdata` no earlier than the cycle after `done`.
- If `req` and `done` coincide, the next T1 follows the final T-state directly. `done` and strobes never glitch across the boundary: `mreq` goes high for at least one cycle between cycles only in the fetch case (T3/T4). Read or write back-to-back keeps `mreq` low continuously.
- `wait_n` is ignored in every state except T2 and TW.

## Structure
- Shared package `z80_bus_pkg`:
  - cycle-type constants `CYC_FETCH`=2'b00, `CYC_READ`=2'b01, `CYC_WRITE`=2'b10
  - state encoding constants for IDLE/T1/T2/TW/T3/T4
- Single module with no sub-modules. The state register, latched request registers and output decode live in one file. `wait_n` synchronisation is the responsibility of the top level.

## Test plan
- Fetch, `req_addr`=0x0123, `din`=0xC3, `wait_n`=1: `m1`/`mreq`/`rd` low for exactly 2 cycles, `done` in cycle 4, `rdata`=0xC3, `address`=0x0123 throughout.
- Write, `req_addr`=0x0100, `req_wdata`=0x5A, `wait_n` low for 2 samples: `wr` low for 4 cycles (T2, TW, TW, T3), `mreq` low for 5 cycles, `dout`=0x5A, `done` in cycle 5.
- Read back-to-back with a fetch (`req` held with `done`): read 0x0050 returns `din`=0x11, `mreq` stays low across the boundary, and the fetch T1 follows with no IDLE cycle.
- `req_type`=11 with `req`=1 for 3 cycles: strobes all stay high, `done` is never asserted, `ready` stays 1.
- Reset during a read's TW: all strobes go to 1 and `address` to 0 without waiting for a clock edge. After release, a fetch at 0x0000 completes normally in 4 cycles.
- `req_addr` changed to 0xFFFF during T2 of a read at 0x0200: `address` stays 0x0200 until `done`.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus-cycle sequencer: cycle types and T-state encoding.
package z80_bus_pkg;

  localparam logic [1:0] CYC_FETCH = 2'b00;
  localparam logic [1:0] CYC_READ  = 2'b01;
  localparam logic [1:0] CYC_WRITE = 2'b10;
  localparam logic [1:0] CYC_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5
  } state_t;

endpackage

// File: rtl/z80_bus_sequencer.sv
// Z80 bus-cycle sequencer: turns single-cycle core requests into T-state
// accurate active-low m1/mreq/rd/wr strobes with address, write data and
// captured read data. No refresh cycle is generated.
//
// Handshake: a request is taken on the rising edge where ready=1, req=1 and
// req_type != 2'b11. ready is a registered output and never depends on req.
// done is a one-cycle pulse in the final T-state; ready is also high then,
// so a request presented alongside done starts the next T1 immediately.
module z80_bus_sequencer
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [1:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              m1,
  output logic              mreq,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dout,
  input  logic [DATA_W-1:0] din,
  input  logic              wait_n,
  output logic [2:0]        state_dbg
);

  state_t     state;
  state_t     state_nx;
  logic [1:0] cyc_q;
  logic [1:0] cyc_nx;
  logic       accept;
  logic       cap_en;
  logic       m1_d;
  logic       mreq_d;
  logic       rd_d;
  logic       wr_d;
  logic       done_d;
  logic       ready_d;

  assign state_dbg = state;

  // Request acceptance and the cycle type that the next state will run under.
  always_comb begin
    accept = ready && req && (req_type != CYC_RSVD);
    cyc_nx = accept ? req_type : cyc_q;
  end

  // Next-state logic; wait_n only matters when leaving T2 or TW.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_T1;
      ST_T1:   state_nx = ST_T2;
      ST_T2,
      ST_TW:   state_nx = wait_n ? ST_T3 : ST_TW;
      ST_T3: begin
        if (cyc_q == CYC_FETCH) state_nx = ST_T4;
        else                    state_nx = accept ? ST_T1 : ST_IDLE;
      end
      ST_T4:   state_nx = accept ? ST_T1 : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Strobe/done/ready decode from the next state so the registered outputs
  // line up with the state they belong to.
  always_comb begin
    m1_d   = 1'b1;
    mreq_d = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    done_d = 1'b0;
    case (state_nx)
      ST_T1: begin
        mreq_d = 1'b0;
        m1_d   = (cyc_nx != CYC_FETCH);
        rd_d   = (cyc_nx == CYC_WRITE);
      end
      ST_T2,
      ST_TW: begin
        mreq_d = 1'b0;
        m1_d   = (cyc_nx != CYC_FETCH);
        rd_d   = (cyc_nx == CYC_WRITE);
        wr_d   = (cyc_nx != CYC_WRITE);
      end
      ST_T3: begin
        // Fetch releases its strobes in T3; read/write finish here.
        if (cyc_nx != CYC_FETCH) begin
          mreq_d = 1'b0;
          rd_d   = (cyc_nx == CYC_WRITE);
          wr_d   = (cyc_nx != CYC_WRITE);
          done_d = 1'b1;
        end
      end
      ST_T4:   done_d = 1'b1;
      default: ;
    endcase
    ready_d = (state_nx == ST_IDLE) || done_d;
  end

  // Fetch samples din leaving T2/TW; read samples it leaving T3.
  always_comb begin
    cap_en = ((cyc_q == CYC_FETCH) && ((state == ST_T2) || (state == ST_TW)) &&
              (state_nx == ST_T3)) ||
             ((cyc_q == CYC_READ) && (state == ST_T3));
  end

  // State register and latched request type.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cyc_q <= CYC_FETCH;
    end else begin
      state <= state_nx;
      cyc_q <= cyc_nx;
    end
  end

  // Registered bus outputs, latched address/write data and captured read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m1      <= 1'b1;
      mreq    <= 1'b1;
      rd      <= 1'b1;
      wr      <= 1'b1;
      done    <= 1'b0;
      ready   <= 1'b1;
      address <= '0;
      dout    <= '0;
      rdata   <= '0;
    end else begin
      m1    <= m1_d;
      mreq  <= mreq_d;
      rd    <= rd_d;
      wr    <= wr_d;
      done  <= done_d;
      ready <= ready_d;
      if (accept) address <= req_addr;
      if (accept && (req_type == CYC_WRITE)) dout <= req_wdata;
      if (cap_en) rdata <= din;
    end
  end

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// Bench for z80_bus_sequencer: directed transfers with hand-derived cycle
// lengths and strobe counts, checked by a negedge monitor against a queue.
module tb_z80_bus_sequencer;
  import z80_bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0]    t;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdat;
    logic [7:0]    len;
    logic [7:0]    n_m1;
    logic [7:0]    n_mreq;
    logic [7:0]    n_rd;
    logic [7:0]    n_wr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [1:0]    req_type;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          ready;
  logic          done;
  logic [DW-1:0] rdata;
  logic          m1;
  logic          mreq;
  logic          rd;
  logic          wr;
  logic [AW-1:0] address;
  logic [DW-1:0] dout;
  logic [DW-1:0] din;
  logic          wait_n;
  logic [2:0]    state_dbg;

  logic [DW-1:0] mem [0:65535];
  exp_t          exp_q[$];
  int            chk_cnt = 0;
  int            pass_cnt = 0;
  int            wait_left = 0;

  z80_bus_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready), .done(done),
    .rdata(rdata), .m1(m1), .mreq(mreq), .rd(rd), .wr(wr),
    .address(address), .dout(dout), .din(din), .wait_n(wait_n),
    .state_dbg(state_dbg)
  );

  // Clock and bus memory model.
  always #5 clk = ~clk;
  assign din = mem[address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Wait-state generator: burns wait_left in T2/TW, random wait_n elsewhere.
  always begin
    @(posedge clk);
    #2;
    if (state_dbg == ST_T2 || state_dbg == ST_TW) begin
      if (wait_left > 0) begin
        wait_n = 1'b0;
        wait_left--;
      end else begin
        wait_n = 1'b1;
      end
    end else begin
      wait_n = 1'($urandom_range(0, 1));
    end
  end

  // Driver: wait for ready, present a request, push its expectation.
  task automatic issue(input logic [1:0] t, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int nw, input bit keep);
    exp_t e;
    int   n = 0;
    while (!ready) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        fail_now("issue_ready");
        return;
      end
    end
    e.t      = t;
    e.addr   = a;
    e.wdata  = d;
    e.rdat   = mem[a];
    e.len    = 8'((t == CYC_FETCH) ? 4 + nw : 3 + nw);
    e.n_m1   = 8'((t == CYC_FETCH) ? 2 + nw : 0);
    e.n_mreq = 8'((t == CYC_FETCH) ? 2 + nw : 3 + nw);
    e.n_rd   = 8'((t == CYC_FETCH) ? 2 + nw : (t == CYC_READ) ? 3 + nw : 0);
    e.n_wr   = 8'((t == CYC_WRITE) ? 2 + nw : 0);
    exp_q.push_back(e);
    wait_left = nw;
    req       = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    if (!keep) begin
      req       = 1'b0;
      req_type  = 2'($urandom_range(0, 3));
      req_addr  = 16'hFFFF;
      req_wdata = 8'($urandom_range(0, 255));
    end
  endtask

  // Monitor / scoreboard state.
  exp_t          cur;
  bit            active = 0;
  bit            fin;
  bit            rd_pend = 0;
  bit            b2b_pend = 0;
  bit            b2b_mreq = 0;
  bit            addr_bad;
  bit            dout_bad;
  logic [DW-1:0] rd_exp;
  int            cnt_len, c_m1, c_mreq, c_rd, c_wr;

  // Monitor: samples on the falling edge and retires transactions on done.
  always @(negedge clk) begin
    if (reset) begin
      active   = 0;
      rd_pend  = 0;
      b2b_pend = 0;
      exp_q.delete();
    end else begin
      if (rd_pend) begin
        chk("rdata_after_done", 32'(rdata), 32'(rd_exp));
        rd_pend = 0;
      end
      if (b2b_pend) begin
        chk("b2b_next_is_t1", 32'(state_dbg), 32'(ST_T1));
        if (b2b_mreq) chk("b2b_mreq_low", 32'(mreq), 32'(1'b0));
        b2b_pend = 0;
      end
      fin = 0;
      if (active) begin
        cur = exp_q[0];
        cnt_len++;
        if (!m1)   c_m1++;
        if (!mreq) c_mreq++;
        if (!rd)   c_rd++;
        if (!wr)   c_wr++;
        if (address !== cur.addr) addr_bad = 1;
        if (cur.t == CYC_WRITE && dout !== cur.wdata) dout_bad = 1;
        fin = (cnt_len == int'(cur.len));
      end else begin
        chk("idle_strobes", 32'({m1, mreq, rd, wr}), 32'(4'hF));
      end
      chk("done", 32'(done), 32'(fin));
      chk("ready", 32'(ready), 32'(!active || fin));
      if (fin) begin
        void'(exp_q.pop_front());
        chk("m1_low_cycles", 32'(c_m1), 32'(cur.n_m1));
        chk("mreq_low_cycles", 32'(c_mreq), 32'(cur.n_mreq));
        chk("rd_low_cycles", 32'(c_rd), 32'(cur.n_rd));
        chk("wr_low_cycles", 32'(c_wr), 32'(cur.n_wr));
        chk("address_held", 32'(addr_bad), 32'(0));
        if (cur.t == CYC_WRITE) begin
          chk("dout_held", 32'(dout_bad), 32'(0));
          chk("dout_value", 32'(dout), 32'(cur.wdata));
        end
        if (cur.t == CYC_FETCH) chk("fetch_rdata_at_done", 32'(rdata), 32'(cur.rdat));
        if (cur.t != CYC_WRITE) begin
          rd_pend = 1;
          rd_exp  = cur.rdat;
        end
        active = 0;
      end
      if (ready && req && req_type != CYC_RSVD) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 32'(1), 32'(0));
        end else begin
          active   = 1;
          cnt_len  = 0;
          c_m1     = 0;
          c_mreq   = 0;
          c_rd     = 0;
          c_wr     = 0;
          addr_bad = 0;
          dout_bad = 0;
          if (fin) begin
            b2b_pend = 1;
            b2b_mreq = (cur.t != CYC_FETCH);
          end
        end
      end
    end
  end

  // Stimulus sequence and final report.
  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i[7:0] ^ i[15:8] ^ 8'h5A);
    mem[16'h0123] = 8'hC3;
    mem[16'h0050] = 8'h11;
    reset     = 1'b1;
    req       = 1'b0;
    req_type  = CYC_FETCH;
    req_addr  = '0;
    req_wdata = '0;
    wait_n    = 1'b1;
    #3;
    chk("rst_strobes", 32'({m1, mreq, rd, wr}), 32'(4'hF));
    chk("rst_ready", 32'(ready), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_address", 32'(address), 32'(0));
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue(CYC_FETCH, 16'h0123, 8'h00, 0, 0);
    issue(CYC_WRITE, 16'h0100, 8'h5A, 2, 0);
    issue(CYC_READ,  16'h0050, 8'h00, 0, 1);
    issue(CYC_FETCH, 16'h0051, 8'h00, 0, 0);
    issue(CYC_READ,  16'h0200, 8'h00, 1, 0);

    // Reserved type held for three cycles must be ignored.
    n = 0;
    while (!ready || exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        fail_now("idle_before_reserved");
        break;
      end
    end
    req      = 1'b1;
    req_type = CYC_RSVD;
    req_addr = 16'h0777;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    req = 1'b0;

    issue(CYC_WRITE, 16'h1234, 8'hA7, 0, 0);
    issue(CYC_READ,  16'h1234, 8'h00, 3, 0);
    issue(CYC_WRITE, 16'h0400, 8'h3C, 0, 1);
    issue(CYC_WRITE, 16'h0401, 8'hC5, 1, 0);

    // Asynchronous reset in the middle of a read's wait states.
    issue(CYC_READ, 16'h0300, 8'h00, 100, 0);
    n = 0;
    while (state_dbg != ST_TW) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        fail_now("reach_tw");
        break;
      end
    end
    #2 reset = 1'b1;
    wait_left = 0;
    #1;
    chk("async_rst_strobes", 32'({m1, mreq, rd, wr}), 32'(4'hF));
    chk("async_rst_address", 32'(address), 32'(0));
    chk("async_rst_dout", 32'(dout), 32'(0));
    chk("async_rst_rdata", 32'(rdata), 32'(0));
    chk("async_rst_ready", 32'(ready), 32'(1));
    chk("async_rst_done", 32'(done), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue(CYC_FETCH, 16'h0000, 8'h00, 0, 0);

    n = 0;
    while (exp_q.size() != 0 || active) begin
      @(posedge clk);
      n++;
      if (n > 200) begin
        fail_now("drain");
        break;
      end
    end
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
